// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multicycle MIPS datapath: decodes opcode/funct, drives
// every select/strobe per state, stalls on mem_ready and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  // rdy_gate marks states whose completion strobes only fire in the mem_ready cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       rdy_gate;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    case (op)
      OP_RTYPE:     s = funct_legal(fn) ? R_EXEC : TRAP;
      OP_LW, OP_SW: s = MEM_ADDR;
      OP_BEQ:       s = BRANCH;
      OP_J:         s = JUMP;
      OP_ADDI:      s = ADDI_EXEC;
      default:      s = TRAP;
    endcase
    return s;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
    state_t n;
    case (s)
      FETCH:     n = rdy ? DECODE : FETCH;
      DECODE:    n = decode_next(op, fn);
      MEM_ADDR:  n = (op == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:    n = rdy ? MEM_WB : MEM_RD;
      MEM_WR:    n = rdy ? FETCH : MEM_WR;
      R_EXEC:    n = R_WB;
      ADDI_EXEC: n = ADDI_WB;
      TRAP:      n = TRAP;
      default:   n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read    = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
        c.ir_write    = 1'b1;
        c.pc_write    = 1'b1;
        c.rdy_gate    = 1'b1;
      end
      DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = ALU_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      MEM_WR: begin
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = 1'b1;
        c.rdy_gate   = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = r_alu_op(fn);
      end
      R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_control   = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.instr_done    = 1'b1;
      end
      JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
      end
      ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state_q;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             rdy_ok;
  logic             strobe_ok;

  // Branch qualification by zero happens in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_nxt = next_state(state_q, opcode, funct, mem_ready);
  end

  // Outputs for the upcoming state are registered together with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ctrl_q    <= state_ctrl(FETCH, funct);
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= state_ctrl(state_nxt, funct);
      if (state_nxt == TRAP) illegal_q <= 1'b1;
      if (instr_done)        count_q   <= count_q + CNT_ONE;
    end
  end

  assign strobe_ok = ~reset;
  assign rdy_ok    = ~ctrl_q.rdy_gate | mem_ready;

  assign pc_write      = ctrl_q.pc_write & rdy_ok & strobe_ok;
  assign ir_write      = ctrl_q.ir_write & rdy_ok & strobe_ok;
  assign instr_done    = ctrl_q.instr_done & rdy_ok & strobe_ok;
  assign pc_write_cond = ctrl_q.pc_write_cond & strobe_ok;
  assign mem_read      = ctrl_q.mem_read & strobe_ok;
  assign mem_write     = ctrl_q.mem_write & strobe_ok;
  assign reg_write     = ctrl_q.reg_write & strobe_ok;
  assign iord          = ctrl_q.iord;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_control   = ctrl_q.alu_control;
  assign pc_source     = ctrl_q.pc_source;
  assign illegal       = illegal_q;
  assign state         = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state traces built from the decode rules,
// with randomized wait states, compared cycle by cycle against the DUT.
module tb_multicycle_control;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = 6'h00;
  logic [5:0]       funct = 6'h00;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_control;
  logic [1:0]       pc_source;
  logic             instr_done, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_ill = 1'b0;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       instr_done, illegal;
  } ctl_t;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_ADDI = 5, C_TRAP = 6;

  ctl_t obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_source,
                instr_done, illegal};

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
             ? C_R : C_TRAP;
    case (op)
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      6'h08:   return C_ADDI;
      default: return C_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Required output vector for one cycle spent in state st.
  function automatic ctl_t expect_ctl(input int st, input logic [5:0] fn, input logic rdy,
                                      input logic ill);
    ctl_t e;
    e = '0;
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
                e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; end
      2, 10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_control = alu_for_funct(fn); end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    e.illegal = ill;
    return e;
  endfunction

  // One clock: inputs applied just after the edge, outputs checked on the falling edge.
  task automatic step(input int est, input logic rdy, input string tag);
    ctl_t e;
    mem_ready = rdy;
    zero = 1'($urandom);
    @(negedge clk);
    if (est == 12) m_ill = 1'b1;
    e = expect_ctl(est, funct, rdy, m_ill);
    check_val({tag, "_state"}, 32'(state), 32'(est));
    check_val({tag, "_ctl"}, {13'b0, obs}, {13'b0, e});
    check_val({tag, "_cnt"}, 32'(instr_count), 32'(m_count));
    if (e.instr_done) m_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      check_val("rst_strobes",
                {25'b0, pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write,
                 instr_done}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    m_count = '0;
    m_ill = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                           input int mstall, input int trap_cycles, input string tag);
    opcode = op;
    funct = fn;
    for (int i = 0; i < fstall; i++) step(0, 1'b0, tag);
    step(0, 1'b1, tag);
    step(1, 1'($urandom), tag);
    case (classify(op, fn))
      C_R:    begin step(6, 1'($urandom), tag); step(7, 1'($urandom), tag); end
      C_LW: begin
        step(2, 1'($urandom), tag);
        for (int i = 0; i < mstall; i++) step(3, 1'b0, tag);
        step(3, 1'b1, tag);
        step(4, 1'($urandom), tag);
      end
      C_SW: begin
        step(2, 1'($urandom), tag);
        for (int i = 0; i < mstall; i++) step(5, 1'b0, tag);
        step(5, 1'b1, tag);
      end
      C_BEQ:  step(8, 1'($urandom), tag);
      C_J:    step(9, 1'($urandom), tag);
      C_ADDI: begin step(10, 1'($urandom), tag); step(11, 1'($urandom), tag); end
      default: for (int i = 0; i < trap_cycles; i++) step(12, 1'($urandom), tag);
    endcase
  endtask

  initial begin
    logic [5:0] sweep [5];
    logic [5:0] pool_op [10];
    logic [5:0] pool_fn [10];
    sweep = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    pool_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    pool_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h04, 6'h08, 6'h03, 6'h10, 6'h05};

    @(posedge clk);
    #1;
    apply_reset(2);

    run_instr(6'h00, 6'h20, 0, 0, 0, "radd");
    check_val("radd_count", 32'(instr_count), 32'd1);
    run_instr(6'h23, 6'h04, 0, 2, 0, "lw");
    run_instr(6'h04, 6'h03, 0, 0, 0, "beq_a");
    run_instr(6'h04, 6'h03, 0, 0, 0, "beq_b");
    foreach (sweep[i]) run_instr(6'h00, sweep[i], 0, 0, 0, "sweep");

    run_instr(6'h00, 6'h27, 0, 0, 20, "trap");
    check_val("trap_illegal", 32'(illegal), 32'd1);
    apply_reset(1);
    check_val("trap_clr_state", 32'(state), 32'd0);
    check_val("trap_clr_illegal", 32'(illegal), 32'd0);

    run_instr(6'h02, 6'h10, 3, 0, 0, "jmp");
    run_instr(6'h2B, 6'h08, 3, 1, 0, "sw");

    // Abandon a store while it is still waiting on memory.
    opcode = 6'h2B;
    funct = 6'h08;
    step(0, 1'b1, "abort");
    step(1, 1'b1, "abort");
    step(2, 1'b1, "abort");
    step(5, 1'b0, "abort");
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_val("abort_rst_state", 32'(state), 32'd5);
    check_val("abort_rst_memwrite", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_count = '0;
    m_ill = 1'b0;
    check_val("abort_next_state", 32'(state), 32'd0);
    check_val("abort_next_count", 32'(instr_count), 32'd0);

    for (int i = 0; i < 15; i++) run_instr(6'h00, 6'h20, 0, 0, 0, "wrap");
    check_val("wrap_15", 32'(instr_count), 32'd15);
    run_instr(6'h08, 6'h00, 0, 0, 0, "wrap");
    check_val("wrap_0", 32'(instr_count), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) begin
        logic [5:0] rop, rfn;
        rop = 6'($urandom);
        rfn = 6'($urandom);
        run_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(1, 4), "rnd");
        if (classify(rop, rfn) == C_TRAP) apply_reset($urandom_range(1, 2));
      end else begin
        run_instr(pool_op[k], pool_fn[k], $urandom_range(0, 3), $urandom_range(0, 3), 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
